// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: word field layout, widths and FSM states.
// Imported by the decode stage and its immediate sign extender.
package decode_stage_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int IMM10_W = 10;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int EXT_BIT = 10;
  localparam int IMM_HI = 9;
  localparam int IMM_LO = 0;

  typedef enum logic {
    S_OPC = 1'b0,
    S_IMM = 1'b1
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } fields_t;

endpackage

// File: rtl/decode_stage_imm_sext.sv
// Combinational sign extender for the short 10-bit immediate.
import decode_stage_pkg::*;

module imm_sext #(
  parameter int DATA_W = 32
) (
  input  logic [IMM10_W-1:0] imm10_i,
  output logic [DATA_W-1:0]  imm_o
);

  assign imm_o = {{(DATA_W-IMM10_W){imm10_i[IMM10_W-1]}}, imm10_i};

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits opcode words, merges optional extension immediates,
// and presents one decoded instruction per handshake to execute.
import decode_stage_pkg::*;

module decode_stage #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_ip,
  input  logic [DATA_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_op,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_ip,
  output logic              out_ext
);

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic                ext_q, ext_d;
  fields_t             out_f_q, out_f_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [ADDR_W-1:0]   ip_q, ip_d;
  fields_t             hold_f_q, hold_f_d;
  logic [ADDR_W-1:0]   hold_ip_q, hold_ip_d;

  logic [DATA_W-1:0]   sext_imm;
  fields_t             word_f;
  logic                accept;
  logic                out_fire;

  imm_sext #(
    .DATA_W (DATA_W)
  ) u_imm_sext (
    .imm10_i (in_word[IMM_HI:IMM_LO]),
    .imm_o   (sext_imm)
  );

  assign word_f.op  = in_word[OP_HI:OP_LO];
  assign word_f.rd  = in_word[RD_HI:RD_LO];
  assign word_f.rs1 = in_word[RS1_HI:RS1_LO];
  assign word_f.rs2 = in_word[RS2_HI:RS2_LO];

  assign in_ready = RESET_N & ~flush & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ext_d     = ext_q;
    out_f_d   = out_f_q;
    imm_d     = imm_q;
    ip_d      = ip_q;
    hold_f_d  = hold_f_q;
    hold_ip_d = hold_ip_q;
    if (flush) begin
      state_d = S_OPC;
      valid_d = 1'b0;
    end else begin
      if (out_fire) valid_d = 1'b0;
      if (accept) begin
        unique case (state_q)
          S_OPC: begin
            if (in_word[EXT_BIT]) begin
              hold_f_d  = word_f;
              hold_ip_d = in_ip;
              state_d   = S_IMM;
            end else begin
              out_f_d = word_f;
              imm_d   = sext_imm;
              ext_d   = 1'b0;
              ip_d    = in_ip;
              valid_d = 1'b1;
            end
          end
          S_IMM: begin
            out_f_d = hold_f_q;
            imm_d   = in_word;
            ext_d   = 1'b1;
            ip_d    = hold_ip_q;
            valid_d = 1'b1;
            state_d = S_OPC;
          end
          default: state_d = S_OPC;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_OPC;
      valid_q   <= 1'b0;
      ext_q     <= 1'b0;
      out_f_q   <= '0;
      imm_q     <= '0;
      ip_q      <= '0;
      hold_f_q  <= '0;
      hold_ip_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ext_q     <= ext_d;
      out_f_q   <= out_f_d;
      imm_q     <= imm_d;
      ip_q      <= ip_d;
      hold_f_q  <= hold_f_d;
      hold_ip_q <= hold_ip_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ext   = ext_q;
  assign out_op    = out_f_q.op;
  assign out_rd    = out_f_q.rd;
  assign out_rs1   = out_f_q.rs1;
  assign out_rs2   = out_f_q.rs2;
  assign out_imm   = imm_q;
  assign out_ip    = ip_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases then a random
// stream scored against a queue-based instruction model.
module tb_decode_stage;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ip;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [15:0] out_ip;
  logic        out_ext;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [15:0] ip;
    logic        ext;
  } rec_t;

  int   total = 0;
  int   passed = 0;
  rec_t exp_q[$];
  bit   pend;
  rec_t held;

  decode_stage #(.ADDR_W(16), .DATA_W(32)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ip    (in_ip),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op   (out_op),
    .out_rd   (out_rd),
    .out_rs1  (out_rs1),
    .out_rs2  (out_rs2),
    .out_imm  (out_imm),
    .out_ip   (out_ip),
    .out_ext  (out_ext)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic rec_t dut_rec();
    return '{out_op, out_rd, out_rs1, out_rs2, out_imm, out_ip, out_ext};
  endfunction

  function automatic logic [31:0] mk(int op, int rd, int rs1, int rs2,
                                     int ext, int imm10);
    return 32'(op * (1 << 26) + rd * (1 << 21) + rs1 * (1 << 16)
               + rs2 * (1 << 11) + ext * (1 << 10) + imm10);
  endfunction

  function automatic rec_t dec(logic [31:0] w, logic [15:0] ip);
    rec_t r;
    int   s;
    r.op  = 6'((w >> 26) % 64);
    r.rd  = 5'((w >> 21) % 32);
    r.rs1 = 5'((w >> 16) % 32);
    r.rs2 = 5'((w >> 11) % 32);
    s = int'(w % 1024);
    if (s >= 512) s = s - 1024;
    r.imm = 32'(s);
    r.ip  = ip;
    r.ext = 1'b0;
    return r;
  endfunction

  // One clock: check outputs/in_ready before the edge, then advance model.
  task automatic tick();
    bit rdy_e, acc, fire;
    #1;
    rdy_e = RESET_N && !flush && (exp_q.size() == 0 || out_ready);
    chk("in_ready", 80'(in_ready), 80'(rdy_e));
    chk("out_valid", 80'(out_valid), 80'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0)
      chk("out_rec", 80'(dut_rec()), 80'(exp_q[0]));
    acc  = in_valid && rdy_e;
    fire = out_valid && out_ready;
    @(posedge CLOCK_50);
    if (!RESET_N || flush) begin
      exp_q.delete();
      pend = 0;
    end else begin
      if (fire && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        if (pend) begin
          held.imm = in_word;
          held.ext = 1'b1;
          exp_q.push_back(held);
          pend = 0;
        end else if ((in_word >> 10) % 2 == 1) begin
          held = dec(in_word, in_ip);
          pend = 1;
        end else begin
          exp_q.push_back(dec(in_word, in_ip));
        end
      end
    end
    @(negedge CLOCK_50);
  endtask

  initial begin
    logic [31:0] w1, w2;
    RESET_N = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ip = '0; in_word = '0; pend = 0;
    #2;
    chk("rst_rec", 80'(dut_rec()), 80'd0);
    @(negedge CLOCK_50);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // single short-immediate instruction
    out_ready = 1'b1; in_valid = 1'b1;
    in_word = 32'h0421_03FF; in_ip = 16'h0010;
    tick();
    in_valid = 1'b0;
    chk("r031_valid", 80'(out_valid), 80'd1);
    chk("r031_rec", 80'(dut_rec()),
        80'({6'h01, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 16'h0010, 1'b0}));
    tick();

    // extended instruction
    in_valid = 1'b1; in_word = mk(2, 3, 4, 5, 1, 7); in_ip = 16'h0020;
    tick();
    chk("r032_noout", 80'(out_valid), 80'd0);
    in_word = 32'hDEAD_BEEF; in_ip = 16'h0021;
    tick();
    in_valid = 1'b0;
    chk("r032_rec", 80'(dut_rec()),
        80'({6'd2, 5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF, 16'h0020, 1'b1}));
    tick();
    chk("r032_once", 80'(out_valid), 80'd0);

    // stall with back-to-back words
    w1 = mk(5, 6, 7, 8, 0, 12); w2 = mk(9, 10, 11, 12, 0, 600);
    out_ready = 1'b0; in_valid = 1'b1; in_word = w1; in_ip = 16'h0030;
    tick();
    in_word = w2; in_ip = 16'h0031;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r033_stall_rdy", 80'(in_ready), 80'd0);
      chk("r033_stall_ip", 80'(out_ip), 80'h0030);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("r033_second", 80'(dut_rec()), 80'(dec(w2, 16'h0031)));
    tick();
    tick();

    // flush while an extended instruction is half-assembled
    in_valid = 1'b1; in_word = mk(7, 1, 2, 3, 1, 0); in_ip = 16'h0040;
    tick();
    flush = 1'b1; in_word = 32'h1234_5678; in_ip = 16'h0041;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("r034_noout", 80'(out_valid), 80'd0);
    in_valid = 1'b1; in_word = mk(3, 4, 5, 6, 0, 100); in_ip = 16'h0042;
    tick();
    in_valid = 1'b0;
    chk("r034_next", 80'(dut_rec()),
        80'({6'd3, 5'd4, 5'd5, 5'd6, 32'd100, 16'h0042, 1'b0}));
    tick();

    // asynchronous reset mid-extension
    in_valid = 1'b1; in_word = mk(8, 9, 9, 9, 1, 1); in_ip = 16'h0050;
    tick();
    in_valid = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    chk("r035_valid", 80'(out_valid), 80'd0);
    chk("r035_rec", 80'(dut_rec()), 80'd0);
    exp_q.delete(); pend = 0;
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    in_valid = 1'b1; in_word = mk(1, 2, 3, 4, 0, 5); in_ip = 16'h0060;
    tick();
    in_valid = 1'b0;
    chk("r035_opc", 80'(dut_rec()),
        80'({6'd1, 5'd2, 5'd3, 5'd4, 32'd5, 16'h0060, 1'b0}));
    tick();

    // random stream
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      in_word   = $urandom;
      in_ip     = 16'($urandom);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
